// File: rtl/ysyx_22040931_bru_if.sv
// EX-stage branch resolution bundle: fetch prediction port,
// branch request, registered resolution and perf counters.
interface ysyx_22040931_bru_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
);
  logic [XLEN-1:0]  pred_pc;
  logic             pred_taken;
  logic             ex_valid;
  logic             ex_flush;
  logic [2:0]       ex_funct3;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_imm;
  logic [XLEN-1:0]  ex_rs1;
  logic [XLEN-1:0]  ex_rs2;
  logic             ex_pred_taken;
  logic             res_valid;
  logic             res_taken;
  logic             res_mispredict;
  logic [XLEN-1:0]  res_redirect_pc;
  logic             res_illegal;
  logic [CNT_W-1:0] cnt_branch;
  logic [CNT_W-1:0] cnt_mispred;

  modport master (
    output pred_pc, ex_valid, ex_flush, ex_funct3,
    output ex_pc, ex_imm, ex_rs1, ex_rs2, ex_pred_taken,
    input  pred_taken, res_valid, res_taken, res_mispredict,
    input  res_redirect_pc, res_illegal, cnt_branch, cnt_mispred
  );

  modport slave (
    input  pred_pc, ex_valid, ex_flush, ex_funct3,
    input  ex_pc, ex_imm, ex_rs1, ex_rs2, ex_pred_taken,
    output pred_taken, res_valid, res_taken, res_mispredict,
    output res_redirect_pc, res_illegal, cnt_branch, cnt_mispred
  );
endinterface

// File: rtl/ysyx_22040931_bru.sv
// Branch resolution unit with bimodal 2-bit BHT and
// branch/mispredict performance counters.
module ysyx_22040931_bru #(
  parameter int XLEN    = 64,
  parameter int BHT_IDX = 6,
  parameter int CNT_W   = 32
) (
  input logic clk,
  input logic rst,
  ysyx_22040931_bru_if.slave bus
);
  localparam int NENT = 2 ** BHT_IDX;

  logic              acc;
  logic              upd;
  logic              eq;
  logic              lt;
  logic              ltu;
  logic              cond;
  logic              illegal;
  logic              mis;
  logic [XLEN-1:0]   target;
  logic [XLEN-1:0]   fall;
  logic [XLEN-1:0]   redirect;
  logic [BHT_IDX-1:0] ex_idx;
  logic [BHT_IDX-1:0] pd_idx;
  logic [1:0]        bht [NENT];
  logic [1:0]        bht_cur;
  logic [1:0]        bht_nxt;

  logic              r_valid;
  logic              r_taken;
  logic              r_mis;
  logic [XLEN-1:0]   r_pc;
  logic              r_ill;
  logic [CNT_W-1:0]  c_br;
  logic [CNT_W-1:0]  c_mis;

  logic unused_pc_bits;

  assign acc = bus.ex_valid & ~bus.ex_flush;
  assign upd = acc & ~illegal;

  assign eq  = bus.ex_rs1 == bus.ex_rs2;
  assign lt  = $signed(bus.ex_rs1) < $signed(bus.ex_rs2);
  assign ltu = bus.ex_rs1 < bus.ex_rs2;

  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    case (bus.ex_funct3)
      3'b000:  cond = eq;
      3'b001:  cond = ~eq;
      3'b100:  cond = lt;
      3'b101:  cond = ~lt;
      3'b110:  cond = ltu;
      3'b111:  cond = ~ltu;
      default: illegal = 1'b1;
    endcase
  end

  assign target   = bus.ex_pc + bus.ex_imm;
  assign fall     = bus.ex_pc + XLEN'(4);
  assign redirect = cond ? target : fall;
  assign mis      = ~illegal & (cond != bus.ex_pred_taken);

  assign ex_idx  = bus.ex_pc[BHT_IDX+1:2];
  assign pd_idx  = bus.pred_pc[BHT_IDX+1:2];
  assign bht_cur = bht[ex_idx];

  // Saturating 2-bit counter step
  always_comb begin
    bht_nxt = bht_cur;
    if (cond) begin
      if (bht_cur != 2'b11) bht_nxt = bht_cur + 2'b01;
    end else begin
      if (bht_cur != 2'b00) bht_nxt = bht_cur - 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NENT; i++) bht[i] <= 2'b01;
    end else if (upd) begin
      bht[ex_idx] <= bht_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_taken <= 1'b0;
      r_mis   <= 1'b0;
      r_pc    <= '0;
      r_ill   <= 1'b0;
    end else begin
      r_valid <= acc;
      if (acc) begin
        r_taken <= cond;
        r_mis   <= mis;
        r_pc    <= redirect;
        r_ill   <= illegal;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_br  <= '0;
      c_mis <= '0;
    end else if (upd) begin
      c_br <= c_br + CNT_W'(1);
      if (mis) c_mis <= c_mis + CNT_W'(1);
    end
  end

  assign bus.pred_taken      = bht[pd_idx][1];
  assign bus.res_valid       = r_valid;
  assign bus.res_taken       = r_taken;
  assign bus.res_mispredict  = r_mis;
  assign bus.res_redirect_pc = r_pc;
  assign bus.res_illegal     = r_ill;
  assign bus.cnt_branch      = c_br;
  assign bus.cnt_mispred     = c_mis;

  assign unused_pc_bits = ^{bus.pred_pc[XLEN-1:BHT_IDX+2],
                            bus.pred_pc[1:0]};
endmodule

// File: tb/tb_ysyx_22040931_bru.sv
// Directed self-checking bench for the branch resolution unit.
module tb_ysyx_22040931_bru;
  logic clk;
  logic rst;
  int   total;
  int   fails;

  ysyx_22040931_bru_if bus ();

  ysyx_22040931_bru dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic br(input logic [2:0] f3, input logic [63:0] pc,
                    input logic [63:0] imm, input logic [63:0] a,
                    input logic [63:0] b, input logic pred);
    @(negedge clk);
    bus.ex_valid      = 1'b1;
    bus.ex_flush      = 1'b0;
    bus.ex_funct3     = f3;
    bus.ex_pc         = pc;
    bus.ex_imm        = imm;
    bus.ex_rs1        = a;
    bus.ex_rs2        = b;
    bus.ex_pred_taken = pred;
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b0;
  endtask

  task automatic res(input string tag, input logic v,
                     input logic t, input logic m,
                     input logic [63:0] pc, input logic il);
    chk({tag, "_valid"}, 64'(bus.res_valid), 64'(v));
    chk({tag, "_taken"}, 64'(bus.res_taken), 64'(t));
    chk({tag, "_mis"}, 64'(bus.res_mispredict), 64'(m));
    chk({tag, "_pc"}, bus.res_redirect_pc, pc);
    chk({tag, "_ill"}, 64'(bus.res_illegal), 64'(il));
  endtask

  task automatic cnts(input string tag, input int b, input int m);
    chk({tag, "_cbr"}, 64'(bus.cnt_branch), 64'(b));
    chk({tag, "_cmis"}, 64'(bus.cnt_mispred), 64'(m));
  endtask

  initial begin
    total = 0;
    fails = 0;
    clk = 1'b0;
    rst = 1'b1;
    bus.pred_pc       = '0;
    bus.ex_valid      = 1'b0;
    bus.ex_flush      = 1'b0;
    bus.ex_funct3     = 3'b000;
    bus.ex_pc         = '0;
    bus.ex_imm        = '0;
    bus.ex_rs1        = '0;
    bus.ex_rs2        = '0;
    bus.ex_pred_taken = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    res("rst", 0, 0, 0, 64'h0, 0);
    cnts("rst", 0, 0);
    for (int i = 0; i < 64; i++) begin
      bus.pred_pc = 64'(i) << 2;
      #1;
      chk($sformatf("rst_bht%0d", i), 64'(bus.pred_taken), 64'h0);
    end
    @(negedge clk);
    rst = 1'b0;

    // signed vs unsigned compare on the same operands
    br(3'b100, 64'h100, 64'h40, 64'h8000_0000_0000_0000, 64'h0, 1);
    res("blt", 1, 1, 0, 64'h140, 0);
    cnts("blt", 1, 0);
    br(3'b110, 64'h100, 64'h40, 64'h8000_0000_0000_0000, 64'h0, 1);
    res("bltu", 1, 0, 1, 64'h104, 0);
    cnts("bltu", 2, 1);
    br(3'b101, 64'h204, 64'h8, 64'h5, 64'h5, 0);
    res("bge", 1, 1, 1, 64'h20C, 0);
    cnts("bge", 3, 2);

    br(3'b000, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFF8, 64'h7, 64'h7, 0);
    res("beq", 1, 1, 1, 64'h7FFF_FFF8, 0);
    br(3'b001, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFF8, 64'h7, 64'h7, 0);
    res("bne", 1, 0, 0, 64'h8000_0004, 0);
    cnts("bne", 5, 3);

    // BHT training at index 4: 01 -> 10 -> 11 -> 11 -> 10 -> 01
    bus.pred_pc = 64'h8000_0010;
    #1;
    chk("trn0", 64'(bus.pred_taken), 64'h0);
    br(3'b000, 64'h8000_0010, 64'h20, 64'h1, 64'h1, 0);
    chk("trn1", 64'(bus.pred_taken), 64'h1);
    br(3'b000, 64'h8000_0010, 64'h20, 64'h1, 64'h1, 1);
    chk("trn2", 64'(bus.pred_taken), 64'h1);
    br(3'b000, 64'h8000_0010, 64'h20, 64'h1, 64'h1, 1);
    chk("trn3", 64'(bus.pred_taken), 64'h1);
    br(3'b000, 64'h8000_0010, 64'h20, 64'h1, 64'h2, 1);
    chk("trn4", 64'(bus.pred_taken), 64'h1);
    br(3'b000, 64'h8000_0010, 64'h20, 64'h1, 64'h2, 1);
    chk("trn5", 64'(bus.pred_taken), 64'h0);
    res("trn5", 1, 0, 1, 64'h8000_0014, 0);
    cnts("trn5", 10, 6);

    // flushed branch leaves results held and counters frozen
    @(negedge clk);
    bus.ex_valid  = 1'b1;
    bus.ex_flush  = 1'b1;
    bus.ex_funct3 = 3'b000;
    bus.ex_pc     = 64'h8000_0010;
    bus.ex_rs1    = 64'h3;
    bus.ex_rs2    = 64'h3;
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b0;
    bus.ex_flush = 1'b0;
    res("flush", 0, 0, 1, 64'h8000_0014, 0);
    cnts("flush", 10, 6);
    chk("flush_bht", 64'(bus.pred_taken), 64'h0);

    br(3'b010, 64'h300, 64'h40, 64'h9, 64'h9, 1);
    res("ill", 1, 0, 0, 64'h304, 1);
    cnts("ill", 10, 6);

    br(3'b000, 64'hFFFF_FFFF_FFFF_FFFC, 64'h40, 64'h1, 64'h2, 0);
    res("wrap", 1, 0, 0, 64'h0, 0);
    cnts("wrap", 11, 6);

    // async reset in the middle of a burst
    br(3'b000, 64'h8000_0010, 64'h20, 64'h1, 64'h1, 0);
    cnts("pre_rst", 12, 7);
    bus.pred_pc = 64'h8000_0010;
    #1;
    chk("pre_rst_pred", 64'(bus.pred_taken), 64'h1);
    @(negedge clk);
    bus.ex_valid      = 1'b1;
    bus.ex_funct3     = 3'b000;
    bus.ex_pc         = 64'h8000_0010;
    bus.ex_rs1        = 64'h1;
    bus.ex_rs2        = 64'h1;
    bus.ex_pred_taken = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    res("arst", 0, 0, 0, 64'h0, 0);
    cnts("arst", 0, 0);
    chk("arst_bht", 64'(bus.pred_taken), 64'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.ex_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_valid", 64'(bus.res_valid), 64'h0);
    cnts("post_rst", 0, 0);

    br(3'b100, 64'h400, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0);
    res("resume", 1, 1, 1, 64'h410, 0);
    cnts("resume", 1, 1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/ysyx_22040931_bru.md
Name: ysyx_22040931_bru

Overview:
Parametrised branch resolution unit for the EX stage with a built-in bimodal branch history table (BHT). It evaluates all six RV conditional-branch conditions at XLEN width and computes target and fall-through PCs. It registers a one-cycle resolution result that carries a mispredict/redirect indication back to fetch. It also trains a table of 2-bit saturating counters that fetch reads for taken/not-taken prediction, and keeps performance counters.

Parameters:
XLEN, 64, operand and PC width
BHT_IDX, 6, log2 of BHT entries (64 entries); index = pc[BHT_IDX+1:2]
CNT_W, 32, width of performance counters

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
pred_pc  input  XLEN  fetch PC to predict
pred_taken  output  1  combinational: MSB of BHT[pred_pc index]
ex_valid  input  1  branch instruction present in EX this cycle
ex_flush  input  1  squash EX this cycle; ex_valid ignored
ex_funct3  input  3  branch funct3 (000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu)
ex_pc  input  XLEN  PC of the branch
ex_imm  input  XLEN  sign-extended B-immediate
ex_rs1  input  XLEN  operand 1
ex_rs2  input  XLEN  operand 2
ex_pred_taken  input  1  prediction fetch used for this branch
res_valid  output  1  registered: resolution valid
res_taken  output  1  registered: condition true
res_mispredict  output  1  registered: res_taken != ex_pred_taken
res_redirect_pc  output  XLEN  registered: taken ? pc+imm : pc+4
res_illegal  output  1  registered: funct3 is 010 or 011
cnt_branch  output  CNT_W  resolved legal branches
cnt_mispred  output  CNT_W  mispredicted legal branches

Behaviour:
- Reset (async, rst=1): all res_* outputs = 0; cnt_branch = cnt_mispred = 0; every BHT entry = 2'b01 (weakly not-taken). Releases cleanly mid-stream; an in-flight EX branch during reset is lost.
- Accept condition: acc = ex_valid & ~ex_flush. res_valid <= acc on every rising edge. res_* other fields update only when acc; they hold otherwise.
- Conditions (XLEN-wide):
  - eq: rs1==rs2.
  - lt signed: $signed compare; must be correct when the MSBs differ (rs1 = 1<<(XLEN-1) is less than 0).
  - ltu: unsigned compare.
  - bge = ~lt; bgeu = ~ltu; bne = ~eq.
- Arithmetic: target = ex_pc + ex_imm and fallthrough = ex_pc + 4, both modulo 2^XLEN (wrap, no trap).
- Illegal funct3 (010/011): res_illegal=1, res_taken=0, res_mispredict=0, res_redirect_pc=pc+4; no BHT update, no counter increment.
- Latency: resolution visible exactly 1 cycle after the accepting edge. The BHT write occurs on the same edge as the res_* register update.
- BHT update on a legal accept, index i = ex_pc[BHT_IDX+1:2]:
  - taken: counter increments, saturating at 11.
  - not taken: counter decrements, saturating at 00.
- BHT read: pred_taken is a combinational read of the registered table.
  - Same-cycle read/write to the same index returns the old value (no bypass).
  - Aliasing between PCs sharing an index is permitted.
- Counters: cnt_branch +1 per legal accept; cnt_mispred +1 when it is also mispredicted. Both wrap modulo 2^CNT_W.
- ex_flush=1 with ex_valid=1: no resolution, no BHT or counter change; res_valid=0 next cycle.
- Back-to-back branches: one per cycle sustained. Consecutive updates to the same index accumulate (second update sees the first's result).

Test Plan:
- Reset: hold rst 3 cycles → all res_*=0, counters 0; sweep pred_pc over 64 indices → pred_taken=0 for each (state 01).
- Signed vs unsigned: blt with rs1=0x8000_0000_0000_0000, rs2=0 → taken. bltu with the same operands → not taken. bge with rs1=rs2=5 → taken.
- Redirect/mispredict: beq pc=0x8000_0000, imm=-8, rs1=rs2, pred=0 → next cycle res_taken=1, mispredict=1, redirect=0x7FFF_FFF8. bne with rs1=rs2, pred=0 → redirect=0x8000_0004, mispredict=0.
- BHT training: 3 taken beq at pc=0x8000_0010 → pred_taken at that pc becomes 1 after the first, counter saturates at 11. Then 2 not-taken → counter 01, pred_taken=0.
- Flush/illegal: ex_valid=1 with ex_flush=1 → res_valid=0, counters unchanged. funct3=010 → res_illegal=1, cnt_branch unchanged.
- Wrap and async reset: pc=0xFFFF_FFFF_FFFF_FFFC, not taken → redirect=0. Assert rst mid-burst (not clock-aligned) → outputs clear immediately, BHT reinitialised.
